pokey_audio_divider: RTL
========================

Name: pokey_audio_divider

Overview:
- Channel-pair frequency divider for the POKEY audio section.
- Holds the AUDF frequency registers for two channels (low/high) and runs one 8-bit down-counter per channel, advanced by base-clock tick pulses.
- Produces one-cycle borrow pulses and toggled tone outputs that feed the distortion/poly stage downstream.
- Optional join mode chains both channels into one 16-bit divider.

Parameters:
- CNT_W, 8, width of each channel's AUDF register and counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- tick_lo  input  1  base-clock enable pulse for the low channel (one clk wide).
- tick_hi  input  1  base-clock enable pulse for the high channel.
- wr_lo  input  1  write strobe, AUDF low register.
- wr_hi  input  1  write strobe, AUDF high register.
- din  input  CNT_W  write data for AUDF registers.
- stimer  input  1  STIMER strobe: force reload of both counters.
- join  input  1  1 = 16-bit joined mode (requires POKEY_DIV_JOIN_EN).
- borrow_lo  output  1  one-cycle pulse on low-channel underflow.
- borrow_hi  output  1  one-cycle pulse on high-channel (or joined) underflow.
- tone_lo  output  1  square output; toggles on each borrow_lo.
- tone_hi  output  1  square output; toggles on each borrow_hi.
- cnt_lo  output  CNT_W  current low counter value (debug/compare).
- cnt_hi  output  CNT_W  current high counter value.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - audf_lo, audf_hi, cnt_lo and cnt_hi are cleared to 0.
  - borrow_lo, borrow_hi, tone_lo and tone_hi are cleared to 0.
  - Reset overrides every other input, including mid-count; there is no residual pulse after reset.
- AUDF write: wr_x=1 stores din into audf_x at the edge. The stored value is visible from the next cycle; the running count is not disturbed.
- Unjoined channel x, per cycle, highest priority first:
  - stimer=1: cnt_x <= audf_x, borrow_x <= 0, tone unchanged.
  - tick_x=1 and cnt_x==0: cnt_x <= audf_x, borrow_x <= 1, tone_x toggles.
  - tick_x=1 and cnt_x!=0: cnt_x <= cnt_x-1, borrow_x <= 0.
  - otherwise: hold, borrow_x <= 0.
- Period: borrow_x fires every audf_x+1 ticks; tone_x period is 2*(audf_x+1) ticks.
- AUDF=0: borrow on every tick; tone toggles every tick.
- Reload value: the audf value held before the current edge. A write and a reload in the same cycle reload the OLD value.
- Latency: borrow is registered. The pulse appears in the cycle after the tick edge in which the counter was 0.
- Ticks without stimer: the first reload after reset loads audf on the first tick, since cnt starts at 0.
- Simultaneous tick_lo and tick_hi: the channels are independent; both may borrow in the same cycle.

Optional Feature:
- Macro POKEY_DIV_JOIN_EN.
- Defined, with join=1:
  - {cnt_hi,cnt_lo} is one 16-bit down-counter advanced by tick_lo; tick_hi is ignored.
  - At 16'h0000 with a tick: reload {audf_hi,audf_lo}, pulse borrow_hi, toggle tone_hi.
  - Otherwise on a tick: decrement the 16-bit value.
  - borrow_lo pulses when the low byte reaches 0x00 on a tick (byte underflow); tone_lo toggles with it.
  - stimer reloads the full 16-bit value.
  - Changing join mid-count does not reload: counters continue from their current values under the new mode.
- Undefined: join is ignored (treated as 0). There is no 16-bit logic; the channels are always independent.

Test Plan:
- Reset then audf_lo=3 via wr_lo; tick_lo every cycle -> borrow_lo pulses every 4 ticks; tone_lo period 8 ticks; cnt_lo sequence 3,2,1,0,3.
- audf_hi=0, tick_hi every cycle -> borrow_hi high every cycle after the first; tone_hi toggles each cycle.
- Counting with audf_lo=5, cnt_lo=2; wr_lo din=9 and stimer in the same cycle -> cnt_lo=5 (old value); next stimer -> cnt_lo=9; no borrow on either stimer.
- rst_n=0 asserted mid-count with cnt_lo=7, tone_lo=1 -> next cycle all outputs 0, cnt_lo=0, tone_lo=0.
- POKEY_DIV_JOIN_EN defined, join=1, audf_hi=0x01, audf_lo=0x02, stimer, then tick_lo continuous -> borrow_hi once every 0x0103 ticks; borrow_lo at each low-byte 0x00 crossing.
- POKEY_DIV_JOIN_EN undefined, join=1 -> behaviour identical to join=0 (repeat the first scenario and require an identical trace).

Source files
------------

// File: rtl/pokey_audio_divider.sv
// -----------------------------------------------------------------------------
// pokey_audio_divider
//
// Channel-pair frequency divider for the POKEY audio section. Holds the AUDF
// frequency registers of a low and a high channel and runs one down-counter
// per channel, advanced by base-clock tick pulses. Each underflow reloads the
// counter from AUDF, emits a one-cycle borrow pulse and toggles the channel's
// square-wave tone output. These outputs feed the distortion/poly stage.
//
// Optional feature, macro POKEY_DIV_JOIN_EN:
//   When defined, join_mode=1 chains {cnt_hi,cnt_lo} into one 2*CNT_W-bit
//   divider clocked by tick_lo. When undefined, join_mode is ignored and the
//   channels are always independent.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   tick_lo    base-clock enable pulse, low channel (one clk wide)
//   tick_hi    base-clock enable pulse, high channel
//   wr_lo      write strobe, AUDF low register
//   wr_hi      write strobe, AUDF high register
//   din        write data for the AUDF registers
//   stimer     force reload of both counters from AUDF
//   join_mode  1 = joined 16-bit mode (only with POKEY_DIV_JOIN_EN);
//              named join_mode because "join" is a reserved word
//   borrow_lo  one-cycle pulse on low-channel underflow
//   borrow_hi  one-cycle pulse on high-channel (or joined) underflow
//   tone_lo    square output, toggles on each low borrow
//   tone_hi    square output, toggles on each high borrow
//   cnt_lo     current low counter value
//   cnt_hi     current high counter value
// -----------------------------------------------------------------------------
module pokey_audio_divider #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_lo,
   input  logic             tick_hi,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic [CNT_W-1:0] din,
   input  logic             stimer,
   input  logic             join_mode,
   output logic             borrow_lo,
   output logic             borrow_hi,
   output logic             tone_lo,
   output logic             tone_hi,
   output logic [CNT_W-1:0] cnt_lo,
   output logic [CNT_W-1:0] cnt_hi
);

   localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);

   logic [CNT_W-1:0] audf_lo;
   logic [CNT_W-1:0] audf_hi;

   logic             join_act;

`ifdef POKEY_DIV_JOIN_EN
   localparam logic [2*CNT_W-1:0] ONE_J = (2*CNT_W)'(1);
   logic [2*CNT_W-1:0] cnt_j;
   logic [2*CNT_W-1:0] cnt_j_dec;

   assign join_act  = join_mode;
   assign cnt_j     = {cnt_hi, cnt_lo};
   assign cnt_j_dec = cnt_j - ONE_J;
`else
   logic unused_join_mode;

   assign join_act         = 1'b0;
   assign unused_join_mode = join_mode;
`endif

   // Stage p0: next-state decode from current counters and strobes
   logic [CNT_W-1:0] cnt_lo_p0;
   logic [CNT_W-1:0] cnt_hi_p0;
   logic             borrow_lo_p0;
   logic             borrow_hi_p0;
   logic             tone_lo_p0;
   logic             tone_hi_p0;

   always_comb begin
      cnt_lo_p0    = cnt_lo;
      cnt_hi_p0    = cnt_hi;
      borrow_lo_p0 = 1'b0;
      borrow_hi_p0 = 1'b0;
      tone_lo_p0   = tone_lo;
      tone_hi_p0   = tone_hi;

      if (join_act) begin
`ifdef POKEY_DIV_JOIN_EN
         // Joined: one wide counter on tick_lo. The low byte underflowing
         // (tick while it is zero) drives the low borrow, including the
         // full wrap where the whole counter reloads.
         if (stimer) begin
            cnt_lo_p0 = audf_lo;
            cnt_hi_p0 = audf_hi;
         end else if (tick_lo) begin
            if (cnt_lo == '0) begin
               borrow_lo_p0 = 1'b1;
               tone_lo_p0   = ~tone_lo;
            end
            if (cnt_j == '0) begin
               cnt_lo_p0    = audf_lo;
               cnt_hi_p0    = audf_hi;
               borrow_hi_p0 = 1'b1;
               tone_hi_p0   = ~tone_hi;
            end else begin
               {cnt_hi_p0, cnt_lo_p0} = cnt_j_dec;
            end
         end
`endif
      end else begin
         if (stimer) begin
            cnt_lo_p0 = audf_lo;
         end else if (tick_lo) begin
            if (cnt_lo == '0) begin
               cnt_lo_p0    = audf_lo;
               borrow_lo_p0 = 1'b1;
               tone_lo_p0   = ~tone_lo;
            end else begin
               cnt_lo_p0 = cnt_lo - ONE_C;
            end
         end

         if (stimer) begin
            cnt_hi_p0 = audf_hi;
         end else if (tick_hi) begin
            if (cnt_hi == '0) begin
               cnt_hi_p0    = audf_hi;
               borrow_hi_p0 = 1'b1;
               tone_hi_p0   = ~tone_hi;
            end else begin
               cnt_hi_p0 = cnt_hi - ONE_C;
            end
         end
      end
   end

   // Stage p1: registered state and outputs. Reloads above read the AUDF
   // value held before this edge, so a same-cycle write is not yet visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         audf_lo   <= '0;
         audf_hi   <= '0;
         cnt_lo    <= '0;
         cnt_hi    <= '0;
         borrow_lo <= 1'b0;
         borrow_hi <= 1'b0;
         tone_lo   <= 1'b0;
         tone_hi   <= 1'b0;
      end else begin
         if (wr_lo) audf_lo <= din;
         if (wr_hi) audf_hi <= din;
         cnt_lo    <= cnt_lo_p0;
         cnt_hi    <= cnt_hi_p0;
         borrow_lo <= borrow_lo_p0;
         borrow_hi <= borrow_hi_p0;
         tone_lo   <= tone_lo_p0;
         tone_hi   <= tone_hi_p0;
      end
   end

endmodule
